// File: rtl/vx_mem_chan_router_if.sv
// Upstream memory bus between the last-level cache and the channel router:
// one request channel (read/write) and one read-response channel.
interface vx_mem_chan_router_if #(
  parameter int ADDR_WIDTH = 26,
  parameter int DATA_WIDTH = 512,
  parameter int TAG_WIDTH  = 8
);
  localparam int BYTEEN_WIDTH = DATA_WIDTH / 8;

  logic                    req_valid;
  logic                    req_ready;
  logic                    req_rw;
  logic [BYTEEN_WIDTH-1:0] req_byteen;
  logic [ADDR_WIDTH-1:0]   req_addr;
  logic [DATA_WIDTH-1:0]   req_data;
  logic [TAG_WIDTH-1:0]    req_tag;

  logic                    rsp_valid;
  logic                    rsp_ready;
  logic [DATA_WIDTH-1:0]   rsp_data;
  logic [TAG_WIDTH-1:0]    rsp_tag;

  // Cache side: issues requests, consumes responses.
  modport master (
    output req_valid, req_rw, req_byteen, req_addr, req_data, req_tag, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_tag
  );

  // Router side: accepts requests, produces responses.
  modport slave (
    input  req_valid, req_rw, req_byteen, req_addr, req_data, req_tag, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_tag
  );
endinterface

// File: rtl/vx_mem_chan_router.sv
// Multi-channel external memory port: address-interleaves requests across
// NUM_CHANNELS DRAM channels, caps outstanding reads per channel with credit
// counters, merges responses round-robin into one registered response port,
// and keeps aggregate perf counters.
module vx_mem_chan_router #(
  parameter int NUM_CHANNELS   = 2,
  parameter int ADDR_WIDTH     = 26,
  parameter int DATA_WIDTH     = 512,
  parameter int TAG_WIDTH      = 8,
  parameter int INTERLEAVE_LSB = 0,
  parameter int MAX_PENDING    = 16,
  parameter int CTR_BITS       = 44,
  localparam int BYTEEN_WIDTH  = DATA_WIDTH / 8,
  localparam int CH_BITS       = $clog2(NUM_CHANNELS),
  localparam int CH_ADDR_WIDTH = ADDR_WIDTH - CH_BITS,
  localparam int PEND_WIDTH    = $clog2(MAX_PENDING) + 1,
  localparam int PR_WIDTH      = CH_BITS + PEND_WIDTH
) (
  input  logic                                  clk,
  input  logic                                  reset,
  vx_mem_chan_router_if.slave                   in_bus,
  output logic [NUM_CHANNELS-1:0]               mem_req_valid,
  output logic [NUM_CHANNELS-1:0]               mem_req_rw,
  input  logic [NUM_CHANNELS-1:0]               mem_req_ready,
  output logic [NUM_CHANNELS*BYTEEN_WIDTH-1:0]  mem_req_byteen,
  output logic [NUM_CHANNELS*CH_ADDR_WIDTH-1:0] mem_req_addr,
  output logic [NUM_CHANNELS*DATA_WIDTH-1:0]    mem_req_data,
  output logic [NUM_CHANNELS*TAG_WIDTH-1:0]     mem_req_tag,
  input  logic [NUM_CHANNELS-1:0]               mem_rsp_valid,
  output logic [NUM_CHANNELS-1:0]               mem_rsp_ready,
  input  logic [NUM_CHANNELS*DATA_WIDTH-1:0]    mem_rsp_data,
  input  logic [NUM_CHANNELS*TAG_WIDTH-1:0]     mem_rsp_tag,
  output logic [CTR_BITS-1:0]                   perf_reads,
  output logic [CTR_BITS-1:0]                   perf_writes,
  output logic [CTR_BITS-1:0]                   perf_latency,
  output logic [PR_WIDTH-1:0]                   pending_reads,
  output logic                                  busy
);
  localparam int SEL_WIDTH = (CH_BITS > 0) ? CH_BITS : 1;
  localparam logic [PEND_WIDTH-1:0] PEND_MAX = PEND_WIDTH'(MAX_PENDING);

  logic [SEL_WIDTH-1:0]     sel;
  logic [CH_ADDR_WIDTH-1:0] fwd_addr;
  logic                     credit_ok;
  logic                     req_fire;
  logic                     rd_fire;
  logic                     wr_fire;
  logic [PEND_WIDTH-1:0]    pend [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0]  pend_inc;
  logic [NUM_CHANNELS-1:0]  pend_dec;
  logic [SEL_WIDTH-1:0]     rr_ptr;
  logic [SEL_WIDTH-1:0]     cand;
  logic [SEL_WIDTH-1:0]     gnt_idx;
  logic                     any_grant;
  logic                     rsp_accept;
  logic                     rsp_fire;

  // Channel select field; a single channel always selects channel 0.
  if (CH_BITS > 0) begin : g_sel
    assign sel = in_bus.req_addr[INTERLEAVE_LSB +: CH_BITS];
  end else begin : g_nosel
    assign sel = '0;
  end

  // Strip the channel select field from the address, shifting upper bits down.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    fwd_addr = '0;
    for (int i = 0; i < CH_ADDR_WIDTH; i++) begin
      fwd_addr[i] = (i < INTERLEAVE_LSB) ? in_bus.req_addr[i] : in_bus.req_addr[i + CH_BITS];
    end
  end

  // Route the request to its channel, gated by that channel's read credit.
  always_comb begin
    credit_ok        = in_bus.req_rw || (pend[sel] < PEND_MAX);
    in_bus.req_ready = mem_req_ready[sel] && credit_ok;
    mem_req_valid    = '0;
    mem_req_valid[sel] = in_bus.req_valid && credit_ok;
  end

  assign mem_req_rw     = {NUM_CHANNELS{in_bus.req_rw}};
  assign mem_req_byteen = {NUM_CHANNELS{in_bus.req_byteen}};
  assign mem_req_addr   = {NUM_CHANNELS{fwd_addr}};
  assign mem_req_data   = {NUM_CHANNELS{in_bus.req_data}};
  assign mem_req_tag    = {NUM_CHANNELS{in_bus.req_tag}};

  assign req_fire = in_bus.req_valid && in_bus.req_ready;
  assign rd_fire  = req_fire && !in_bus.req_rw;
  assign wr_fire  = req_fire && in_bus.req_rw;

  // Per-channel credit events: read issued to a channel, response taken from it.
  always_comb begin
    pend_inc      = '0;
    pend_inc[sel] = rd_fire;
    pend_dec      = mem_rsp_valid & mem_rsp_ready;
  end

  // Outstanding-read counters; a stray response at zero saturates.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (reset) begin
        pend[i] <= '0;
      end else if (pend_inc[i] && !pend_dec[i]) begin
        pend[i] <= pend[i] + 1'b1;
      end else if (pend_dec[i] && !pend_inc[i] && (pend[i] != '0)) begin
        pend[i] <= pend[i] - 1'b1;
      end
    end
  end

  // Flag a response that has no matching outstanding read.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      if (!reset && pend_dec[i] && !pend_inc[i]) begin
        assert (pend[i] != '0)
          else $warning("vx_mem_chan_router: response on channel %0d with no outstanding read", i);
      end
    end
  end

  // Round-robin pick: first valid channel at or after rr_ptr.
  always_comb begin
    any_grant = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int k = 0; k < NUM_CHANNELS; k++) begin
      cand = SEL_WIDTH'((int'(rr_ptr) + k) % NUM_CHANNELS);
      if (!any_grant && mem_rsp_valid[cand]) begin
        any_grant = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  assign rsp_accept = !in_bus.rsp_valid || in_bus.rsp_ready;
  assign rsp_fire   = any_grant && rsp_accept;

  // Ready only to the granted channel, and only when the output register can load.
  always_comb begin
    mem_rsp_ready          = '0;
    mem_rsp_ready[gnt_idx] = rsp_fire;
  end

  // Response valid flag and round-robin pointer.
  always_ff @(posedge clk) begin
    if (reset) begin
      in_bus.rsp_valid <= 1'b0;
      rr_ptr           <= '0;
    end else if (rsp_fire) begin
      in_bus.rsp_valid <= 1'b1;
      rr_ptr           <= SEL_WIDTH'((int'(gnt_idx) + 1) % NUM_CHANNELS);
    end else if (in_bus.rsp_ready) begin
      in_bus.rsp_valid <= 1'b0;
    end
  end

  // Response payload register, loaded on every response fire.
  always_ff @(posedge clk) begin
    // NOTE: payload is qualified by rsp_valid, so it is deliberately left out of reset.
    if (rsp_fire) begin
      in_bus.rsp_data <= mem_rsp_data[int'(gnt_idx) * DATA_WIDTH +: DATA_WIDTH];
      in_bus.rsp_tag  <= mem_rsp_tag[int'(gnt_idx) * TAG_WIDTH +: TAG_WIDTH];
    end
  end

  // Total outstanding reads across all channels.
  always_comb begin
    pending_reads = '0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      pending_reads = pending_reads + PR_WIDTH'(pend[i]);
    end
  end

  // Perf counters; latency integrates outstanding reads every cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_reads   <= '0;
      perf_writes  <= '0;
      perf_latency <= '0;
    end else begin
      perf_reads   <= perf_reads + CTR_BITS'(rd_fire);
      perf_writes  <= perf_writes + CTR_BITS'(wr_fire);
      perf_latency <= perf_latency + CTR_BITS'(pending_reads);
    end
  end

  assign busy = (pending_reads != '0) || in_bus.rsp_valid;

endmodule
